// File: rtl/half_sub_cell.sv
`default_nettype none
// ============================================================================
// Module   : half_sub_cell
// Brief    : Gate-level half subtractor: Y = A ^ B, borrow = ~A & B.
// Revision : 1.0
// ============================================================================
module half_sub_cell (
    input  logic A,
    input  logic B,
    output logic Y,
    output logic borrow
);

    wire w_diff;
    wire w_not_a;
    wire w_borrow;

    xor g_xor_diff   (w_diff,   A,       B);
    not g_not_a      (w_not_a,  A);
    and g_and_borrow (w_borrow, w_not_a, B);

    assign Y      = w_diff;
    assign borrow = w_borrow;

endmodule
`default_nettype wire

// File: rtl/half_subtractor_structural.sv
`default_nettype none
// ============================================================================
// Module   : half_subtractor_structural
// Brief    : Structural half subtractor with registered outputs and a
//            saturating counter of clock edges that sample borrow=1.
// Revision : 1.0
// ============================================================================
module half_subtractor_structural #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    output logic             Y,
    output logic             borrow,
    output logic             Y_q,
    output logic             borrow_q,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_y;
    logic             w_borrow;
    logic             r_y_q;
    logic             r_borrow_q;
    logic [CNT_W-1:0] r_borrow_cnt;

    half_sub_cell u_cell (
        .A      (A),
        .B      (B),
        .Y      (w_y),
        .borrow (w_borrow)
    );

    // Counter holds at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_q        <= 1'b0;
            r_borrow_q   <= 1'b0;
            r_borrow_cnt <= '0;
        end else begin
            r_y_q      <= w_y;
            r_borrow_q <= w_borrow;
            if (w_borrow && (r_borrow_cnt != c_CNT_MAX)) begin
                r_borrow_cnt <= r_borrow_cnt + c_CNT_ONE;
            end
        end
    end

    assign Y          = w_y;
    assign borrow     = w_borrow;
    assign Y_q        = r_y_q;
    assign borrow_q   = r_borrow_q;
    assign borrow_cnt = r_borrow_cnt;

endmodule
`default_nettype wire

// File: tb/tb_half_subtractor_structural.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_subtractor_structural
// Brief    : Directed and random self-checking bench for the half subtractor.
// Revision : 1.0
// ============================================================================
module tb_half_subtractor_structural;

    typedef struct packed {
        logic y;
        logic b;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic       A;
    logic       B;
    logic       Y;
    logic       borrow;
    logic       Y_q;
    logic       borrow_q;
    logic [7:0] borrow_cnt;
    logic       Y_s;
    logic       borrow_s;
    logic       Y_q_s;
    logic       borrow_q_s;
    logic [1:0] borrow_cnt_s;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t last_q   = '0;
    int   exp_cnt8 = 0;
    int   exp_cnt2 = 0;

    half_subtractor_structural #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .Y          (Y),
        .borrow     (borrow),
        .Y_q        (Y_q),
        .borrow_q   (borrow_q),
        .borrow_cnt (borrow_cnt)
    );

    half_subtractor_structural #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .Y          (Y_s),
        .borrow     (borrow_s),
        .Y_q        (Y_q_s),
        .borrow_q   (borrow_q_s),
        .borrow_cnt (borrow_cnt_s)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t truth(input logic a, input logic b);
        case ({a, b})
            2'b00:   return '{y: 1'b0, b: 1'b0};
            2'b01:   return '{y: 1'b1, b: 1'b1};
            2'b10:   return '{y: 1'b1, b: 1'b0};
            default: return '{y: 1'b0, b: 1'b0};
        endcase
    endfunction

    task automatic check_comb(input string tag);
        exp_t e;
        e = truth(A, B);
        check({tag, "_Y"}, {31'd0, Y}, {31'd0, e.y});
        check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, e.b});
        check({tag, "_Y_s"}, {31'd0, Y_s}, {31'd0, e.y});
        check({tag, "_borrow_s"}, {31'd0, borrow_s}, {31'd0, e.b});
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_Y_q"}, {31'd0, Y_q}, {31'd0, last_q.y});
        check({tag, "_borrow_q"}, {31'd0, borrow_q}, {31'd0, last_q.b});
        check({tag, "_cnt8"}, {24'd0, borrow_cnt}, exp_cnt8);
        check({tag, "_cnt2"}, {30'd0, borrow_cnt_s}, exp_cnt2);
        check({tag, "_Y_q_s"}, {31'd0, Y_q_s}, {31'd0, last_q.y});
    endtask

    // Drive one pair, verify comb outputs and that registers have not moved yet,
    // then cross one edge and compare against the scoreboard entry.
    task automatic step(input string tag, input logic a, input logic b);
        exp_t e;
        A = a;
        B = b;
        #1;
        check_comb(tag);
        check_regs({tag, "_pre"});
        sb_q.push_back(truth(a, b));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            last_q = e;
            if (e.b) begin
                if (exp_cnt8 != 255) exp_cnt8++;
                if (exp_cnt2 != 3)   exp_cnt2++;
            end
        end
        check_regs({tag, "_post"});
    endtask

    initial begin
        A   = 1'b0;
        B   = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_regs("reset");

        // Combinational sweep with clock stopped and reset held.
        #23;
        for (int i = 0; i < 4; i++) begin
            A = i[1];
            B = i[0];
            #1;
            check_comb("sweep");
            check_regs("sweep_rst");
            #24;
        end

        #3;
        A      = 1'b0;
        B      = 1'b0;
        rst    = 1'b0;
        clk_en = 1'b1;

        step("idle", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("cnt_borrow", 1'b0, 1'b1);
        check("cnt_five", {24'd0, borrow_cnt}, 32'd5);
        check("sat_three", {30'd0, borrow_cnt_s}, 32'd3);
        for (int i = 0; i < 3; i++) step("cnt_hold", 1'b1, 1'b1);
        check("cnt_still_five", {24'd0, borrow_cnt}, 32'd5);
        for (int i = 0; i < 6; i++) step("sat", 1'b0, 1'b1);
        check("sat_stays_three", {30'd0, borrow_cnt_s}, 32'd3);

        // Mid-cycle reset discards the count; then build count to 4.
        rst = 1'b1;
        #1;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        last_q   = '0;
        check_regs("rst_mid1");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("cnt4", 1'b0, 1'b1);
        check("cnt_four", {24'd0, borrow_cnt}, 32'd4);

        A = 1'b1;
        B = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        last_q   = '0;
        check_regs("async_rst");
        check_comb("async_rst");
        A = 1'b0;
        B = 1'b1;
        @(posedge clk);
        #1;
        check_regs("rst_held");
        check_comb("rst_held");
        rst = 1'b0;
        step("resume", 1'b0, 1'b1);
        check("resume_cnt", {24'd0, borrow_cnt}, 32'd1);

        // Random pairs with a glitch between edges that must not be sampled.
        for (int i = 0; i < 1000; i++) begin
            A = 1'($urandom_range(0, 1));
            B = 1'($urandom_range(0, 1));
            #1;
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/half_subtractor_structural.md
HALF_SUBTRACTOR_STRUCTURAL -- requirements
Module: half_subtractor_structural

Interface
REQ-001 Parameter CNT_W, default 8: width of the borrow-event counter, legal range 2..32.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A  input  1  minuend bit.
REQ-006 B  input  1  subtrahend bit.
REQ-007 Y  output  1  combinational difference bit, A minus B.
REQ-008 borrow  output  1  combinational borrow-out bit.
REQ-009 Y_q  output  1  Y registered on clk.
REQ-010 borrow_q  output  1  borrow registered on clk.
REQ-011 borrow_cnt  output  CNT_W  saturating count of clock edges sampled with borrow=1.

Function
REQ-012 Y SHALL equal A XOR B at all times, with no clock dependence and zero cycles of latency.
REQ-013 borrow SHALL equal (NOT A) AND B at all times, with no clock dependence.
REQ-014 Truth table, (A,B)->(Y,borrow): 00->00, 01->11, 10->10, 11->00.
REQ-015 Y and borrow SHALL be built from gate-level primitives: one XOR, one NOT, one AND; no behavioural arithmetic.
REQ-016 Y and borrow SHALL be valid even while rst=1 or clk is stopped.
REQ-017 X/Z on A or B SHALL propagate per gate semantics; no forced default values.
REQ-018 On each rising clk edge with rst=0: Y_q<=Y, borrow_q<=borrow (latency exactly 1 cycle).
REQ-019 On each rising clk edge with rst=0 and borrow=1: borrow_cnt SHALL increment by 1, holding at all-ones (2^CNT_W-1) once reached, with no wrap.
REQ-020 If borrow=0 at the edge, borrow_cnt SHALL hold its value.
REQ-021 Input changes between clock edges SHALL affect only the combinational outputs; registered outputs sample only the value present at the edge.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clk edge, force Y_q=0, borrow_q=0 and borrow_cnt=0.
REQ-023 Registered outputs SHALL stay at these values while rst=1; Y and borrow are unaffected by reset.
REQ-024 Reset assertion mid-count SHALL discard the count.
REQ-025 On the first rising edge after rst deasserts, the registered outputs SHALL resume normal operation.

Structure
REQ-026 No shared package is needed; CNT_W is a local module parameter.
REQ-027 A single sub-module, half_sub_cell (ports A, B, Y, borrow), SHALL contain the three gate primitives.
REQ-028 The top level SHALL instantiate half_sub_cell once and add the output registers and counter around it.

Verification
REQ-029 Combinational sweep with no clock: A=0,B=0 -> Y=0,borrow=0; A=0,B=1 -> Y=1,borrow=1; A=1,B=0 -> Y=1,borrow=0; A=1,B=1 -> Y=0,borrow=0. Apply each input pair at 25 ns intervals; check each 1 ns after application.
REQ-030 Registered latency: with A=0,B=1 applied before edge n, Y_q=1 and borrow_q=1 after edge n and not before it.
REQ-031 Counter: hold A=0,B=1 for 5 edges -> borrow_cnt=5; then apply A=1,B=1 for 3 edges -> borrow_cnt remains 5.
REQ-032 Saturation, CNT_W=2: hold borrow=1 for 6 edges -> borrow_cnt=3 and stays 3.
REQ-033 Asynchronous reset: assert rst mid-cycle with borrow_cnt=4 -> Y_q, borrow_q and borrow_cnt read 0 before the next edge; Y and borrow still follow A and B.
REQ-034 Random: 1000 random A/B values -> Y and borrow match the REQ-014 truth table every cycle, and Y_q matches the Y value from the previous cycle.
